// File: rtl/decode_pkg.sv
// ---------------------------------------------------------------------------
// decode_pkg
// Shared types and constants for the RV instruction-decode stage.
//   - Base opcode localparams (bits [6:0] of the instruction word)
//   - fmt_e     : instruction format classification
//   - decoded_t : one fully decoded beat (fields, immediate, format,
//                 illegal flag and PC)
// The immediate and PC fields are held at the maximum supported width (64).
// A stage built for XLEN = 32 keeps only the low bits. Because the decoder
// sign-extends all the way to 64, truncating to 32 bits still gives the
// correct sign-extended value.
// ---------------------------------------------------------------------------
package decode_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [6:0]          opcode;
    logic [4:0]          rd;
    logic [2:0]          func3;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [6:0]          func7;
    logic [XLEN_MAX-1:0] imm;
    fmt_e                fmt;
    logic                illegal;
    logic [XLEN_MAX-1:0] pc;
  } decoded_t;

  // This is the value held in the registers after reset or flush: every
  // data field is zero and the format is NONE.
  localparam decoded_t DECODED_RESET = '{
    opcode:  7'd0,
    rd:      5'd0,
    func3:   3'd0,
    rs1:     5'd0,
    rs2:     5'd0,
    func7:   7'd0,
    imm:     '0,
    fmt:     FMT_NONE,
    illegal: 1'b0,
    pc:      '0
  };

endpackage

// File: rtl/instr_field_decode.sv
// ---------------------------------------------------------------------------
// instr_field_decode
// Purely combinational decode of one 32-bit RV instruction word.
// Ports:
//   i_instr   in  32         raw instruction word
//   o_decoded out decoded_t  fields, sign-extended immediate (64-bit),
//                            format, illegal flag; pc is left at 0 and
//                            is filled in by the stage
// ---------------------------------------------------------------------------
module instr_field_decode
  import decode_pkg::*;
(
  input  logic [31:0] i_instr,
  output decoded_t    o_decoded
);

  // The raw fields are always extracted. The format selects which immediate
  // layout is used. An unknown opcode falls through as NONE, flagged illegal,
  // with a zero immediate.
  always_comb begin
    o_decoded         = DECODED_RESET;
    o_decoded.opcode  = i_instr[6:0];
    o_decoded.rd      = i_instr[11:7];
    o_decoded.func3   = i_instr[14:12];
    o_decoded.rs1     = i_instr[19:15];
    o_decoded.rs2     = i_instr[24:20];
    o_decoded.func7   = i_instr[31:25];
    o_decoded.fmt     = FMT_NONE;
    o_decoded.illegal = 1'b1;
    o_decoded.imm     = '0;

    case (i_instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: begin
        o_decoded.fmt = FMT_I;
        o_decoded.imm = {{52{i_instr[31]}}, i_instr[31:20]};
      end
      OPC_STORE: begin
        o_decoded.fmt = FMT_S;
        o_decoded.imm = {{52{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      end
      OPC_BRANCH: begin
        o_decoded.fmt = FMT_B;
        o_decoded.imm = {{51{i_instr[31]}}, i_instr[31], i_instr[7],
                         i_instr[30:25], i_instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        o_decoded.fmt = FMT_U;
        o_decoded.imm = {{32{i_instr[31]}}, i_instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        o_decoded.fmt = FMT_J;
        o_decoded.imm = {{43{i_instr[31]}}, i_instr[31], i_instr[19:12],
                         i_instr[20], i_instr[30:21], 1'b0};
      end
      OPC_OP: begin
        o_decoded.fmt = FMT_R;
        o_decoded.imm = '0;
      end
      default: begin
        o_decoded.fmt = FMT_NONE;
        o_decoded.imm = '0;
      end
    endcase

    // Every listed opcode already ends in 2'b11. The explicit check keeps the
    // illegal flag correct even if the opcode table grows later.
    if ((o_decoded.fmt != FMT_NONE) && (i_instr[1:0] == 2'b11)) begin
      o_decoded.illegal = 1'b0;
    end else begin
      o_decoded.fmt     = FMT_NONE;
      o_decoded.illegal = 1'b1;
      o_decoded.imm     = '0;
    end
  end

endmodule

// File: rtl/instr_decode_stage.sv
// ---------------------------------------------------------------------------
// instr_decode_stage
// Registered RV decode stage between fetch and register-read, built on a
// two-entry skid buffer (main + skid) so in_ready can be a register.
// Parameters:
//   XLEN   immediate/PC width (32 or 64)
//   PC_EN  1 = carry in_pc to out_pc, 0 = out_pc tied to 0
// Ports:
//   clk, rst (sync, active-high), flush (sync discard)
//   in_valid / in_ready / in_instr / in_pc     fetch-side handshake
//   out_valid / out_ready                      consumer-side handshake
//   out_pc, out_opcode, out_rd, out_func3, out_rs1, out_rs2, out_func7,
//   out_imm, out_fmt, out_illegal              decoded beat (from main)
// ---------------------------------------------------------------------------
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit PC_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_func3,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_func7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_e;

  occ_e     r_state;
  logic     r_in_ready;
  decoded_t r_main;
  decoded_t r_skid;

  decoded_t w_field;
  decoded_t w_dec;
  logic     w_accept;
  logic     w_pop;

  instr_field_decode u_field_decode (
    .i_instr   (in_instr),
    .o_decoded (w_field)
  );

  // Attach the PC to the freshly decoded word. The upper bits stay zero when
  // XLEN is narrower than the package width.
  always_comb begin
    w_dec    = w_field;
    w_dec.pc = '0;
    if (PC_EN) begin
      w_dec.pc[XLEN-1:0] = in_pc;
    end
  end

  assign w_accept = in_valid & r_in_ready;
  assign w_pop    = out_valid & out_ready;

  // This block holds the occupancy FSM and the storage. Main always holds
  // the oldest beat. When a beat arrives while main is still held, it is
  // parked in skid and moves into main on the next pop. in_ready is computed
  // from the next state, so it never depends combinationally on out_ready.
  // A flush drops everything, including a beat accepted in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
      r_main     <= DECODED_RESET;
      r_skid     <= DECODED_RESET;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_main  <= w_dec;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          r_in_ready <= 1'b1;
          if (w_accept && !w_pop) begin
            r_skid     <= w_dec;
            r_state    <= ST_TWO;
            r_in_ready <= 1'b0;
          end else if (w_accept && w_pop) begin
            r_main <= w_dec;
          end else if (w_pop) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          r_in_ready <= 1'b0;
          if (w_pop) begin
            r_main     <= r_skid;
            r_state    <= ST_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_EMPTY;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = (r_state != ST_EMPTY);
  assign out_pc      = r_main.pc[XLEN-1:0];
  assign out_opcode  = r_main.opcode;
  assign out_rd      = r_main.rd;
  assign out_func3   = r_main.func3;
  assign out_rs1     = r_main.rs1;
  assign out_rs2     = r_main.rs2;
  assign out_func7   = r_main.func7;
  assign out_imm     = r_main.imm[XLEN-1:0];
  assign out_fmt     = r_main.fmt;
  assign out_illegal = r_main.illegal;

  // When XLEN is 32, the upper halves of the stored immediate and PC are
  // intentionally left unobserved.
  if (XLEN < XLEN_MAX) begin : g_narrow
    logic w_unused_hi;
    assign w_unused_hi = ^{r_main.imm[XLEN_MAX-1:XLEN], r_main.pc[XLEN_MAX-1:XLEN]};
  end

endmodule

// File: tb/tb_instr_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_instr_decode_stage
// Directed bench for instr_decode_stage at XLEN = 64 with PC_EN = 1.
// Each step drives the inputs, advances one clock, and then compares the
// outputs #1 after the rising edge against hand-computed values.
// ---------------------------------------------------------------------------
module tb_instr_decode_stage;

  localparam int XLEN = 64;

  localparam logic [31:0] I_ADDI = 32'hFFF00093;
  localparam logic [31:0] I_SW   = 32'h0020A423;
  localparam logic [31:0] I_BEQ  = 32'hFE000EE3;
  localparam logic [31:0] I_JAL  = 32'h001000EF;
  localparam logic [31:0] I_LUI  = 32'h123452B7;
  localparam logic [31:0] I_ZERO = 32'h00000000;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            inValid;
  logic            inReady;
  logic [31:0]     inInstr;
  logic [XLEN-1:0] inPc;
  logic            outValid;
  logic            outReady;
  logic [XLEN-1:0] outPc;
  logic [6:0]      outOpcode;
  logic [4:0]      outRd;
  logic [2:0]      outFunc3;
  logic [4:0]      outRs1;
  logic [4:0]      outRs2;
  logic [6:0]      outFunc7;
  logic [XLEN-1:0] outImm;
  logic [2:0]      outFmt;
  logic            outIllegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_decode_stage #(.XLEN(XLEN), .PC_EN(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (inValid),
    .in_ready    (inReady),
    .in_instr    (inInstr),
    .in_pc       (inPc),
    .out_valid   (outValid),
    .out_ready   (outReady),
    .out_pc      (outPc),
    .out_opcode  (outOpcode),
    .out_rd      (outRd),
    .out_func3   (outFunc3),
    .out_rs1     (outRs1),
    .out_rs2     (outRs2),
    .out_func7   (outFunc7),
    .out_imm     (outImm),
    .out_fmt     (outFmt),
    .out_illegal (outIllegal)
  );

  // Drive one set of inputs with blocking assignments.
  task automatic applyStimulus(input logic v, input logic [31:0] instr,
                               input logic [XLEN-1:0] pc, input logic rdy,
                               input logic fl);
    inValid  = v;
    inInstr  = instr;
    inPc     = pc;
    outReady = rdy;
    flush    = fl;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, I_ZERO, '0, 1'b0, 1'b0);
    tick();
    tick();

    // Reset values
    checkOutput("rst_valid",   64'(outValid),   64'd0);
    checkOutput("rst_ready",   64'(inReady),    64'd1);
    checkOutput("rst_fmt",     64'(outFmt),     64'd6);
    checkOutput("rst_imm",     outImm,          64'd0);
    checkOutput("rst_opcode",  64'(outOpcode),  64'd0);
    checkOutput("rst_pc",      outPc,           64'd0);
    checkOutput("rst_illegal", 64'(outIllegal), 64'd0);
    rst = 1'b0;

    // addi x1,x0,-1 appears one cycle after acceptance
    applyStimulus(1'b1, I_ADDI, 64'h100, 1'b1, 1'b0);
    tick();
    checkOutput("addi_valid",   64'(outValid),   64'd1);
    checkOutput("addi_opcode",  64'(outOpcode),  64'h13);
    checkOutput("addi_rd",      64'(outRd),      64'd1);
    checkOutput("addi_rs1",     64'(outRs1),     64'd0);
    checkOutput("addi_imm",     outImm,          64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("addi_fmt",     64'(outFmt),     64'd1);
    checkOutput("addi_illegal", 64'(outIllegal), 64'd0);
    checkOutput("addi_pc",      outPc,           64'h100);

    // Back-to-back stream
    applyStimulus(1'b1, I_SW, 64'h104, 1'b1, 1'b0);
    tick();
    checkOutput("sw_valid", 64'(outValid), 64'd1);
    checkOutput("sw_fmt",   64'(outFmt),   64'd2);
    checkOutput("sw_rs1",   64'(outRs1),   64'd1);
    checkOutput("sw_rs2",   64'(outRs2),   64'd2);
    checkOutput("sw_func3", 64'(outFunc3), 64'd2);
    checkOutput("sw_imm",   outImm,        64'd8);
    checkOutput("sw_ready", 64'(inReady),  64'd1);

    applyStimulus(1'b1, I_BEQ, 64'h108, 1'b1, 1'b0);
    tick();
    checkOutput("beq_valid", 64'(outValid), 64'd1);
    checkOutput("beq_fmt",   64'(outFmt),   64'd3);
    checkOutput("beq_imm",   outImm,        64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("beq_func7", 64'(outFunc7), 64'h7F);
    checkOutput("beq_pc",    outPc,         64'h108);

    applyStimulus(1'b1, I_JAL, 64'h10C, 1'b1, 1'b0);
    tick();
    checkOutput("jal_valid", 64'(outValid), 64'd1);
    checkOutput("jal_fmt",   64'(outFmt),   64'd5);
    checkOutput("jal_imm",   outImm,        64'h800);
    checkOutput("jal_rd",    64'(outRd),    64'd1);

    applyStimulus(1'b1, I_LUI, 64'h110, 1'b1, 1'b0);
    tick();
    checkOutput("lui_fmt", 64'(outFmt), 64'd4);
    checkOutput("lui_imm", outImm,      64'h0000_0000_1234_5000);
    checkOutput("lui_rd",  64'(outRd),  64'd5);

    applyStimulus(1'b1, I_ZERO, 64'h114, 1'b1, 1'b0);
    tick();
    checkOutput("zero_valid",   64'(outValid),   64'd1);
    checkOutput("zero_illegal", 64'(outIllegal), 64'd1);
    checkOutput("zero_fmt",     64'(outFmt),     64'd6);
    checkOutput("zero_imm",     outImm,          64'd0);

    applyStimulus(1'b0, I_ZERO, '0, 1'b1, 1'b0);
    tick();
    checkOutput("drain_valid", 64'(outValid), 64'd0);

    // Stall with out_ready low: A and B are accepted, C is held
    applyStimulus(1'b1, I_SW, 64'h200, 1'b0, 1'b0);
    tick();
    checkOutput("stallA_valid", 64'(outValid), 64'd1);
    checkOutput("stallA_ready", 64'(inReady),  64'd1);
    checkOutput("stallA_pc",    outPc,         64'h200);
    applyStimulus(1'b1, I_BEQ, 64'h204, 1'b0, 1'b0);
    tick();
    checkOutput("stallB_ready", 64'(inReady), 64'd0);
    checkOutput("stallB_pc",    outPc,        64'h200);
    applyStimulus(1'b1, I_JAL, 64'h208, 1'b0, 1'b0);
    tick();
    checkOutput("stallC_ready",  64'(inReady),   64'd0);
    checkOutput("stallC_pc",     outPc,          64'h200);
    checkOutput("stallC_opcode", 64'(outOpcode), 64'h23);
    tick();
    checkOutput("stallC2_pc",  outPc,        64'h200);
    checkOutput("stallC2_imm", outImm,       64'd8);
    applyStimulus(1'b1, I_JAL, 64'h208, 1'b1, 1'b0);
    tick();
    checkOutput("relB_pc",    outPc,         64'h204);
    checkOutput("relB_fmt",   64'(outFmt),   64'd3);
    checkOutput("relB_ready", 64'(inReady),  64'd1);
    tick();
    checkOutput("relC_pc",    outPc,         64'h208);
    checkOutput("relC_fmt",   64'(outFmt),   64'd5);
    applyStimulus(1'b0, I_ZERO, '0, 1'b1, 1'b0);
    tick();
    checkOutput("relDrain_valid", 64'(outValid), 64'd0);

    // Flush while in state TWO, with a beat offered
    applyStimulus(1'b1, I_SW, 64'h300, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, I_BEQ, 64'h304, 1'b0, 1'b0);
    tick();
    checkOutput("fl2_full", 64'(inReady), 64'd0);
    applyStimulus(1'b1, I_JAL, 64'h3FC, 1'b0, 1'b1);
    tick();
    checkOutput("fl2_valid", 64'(outValid), 64'd0);
    checkOutput("fl2_ready", 64'(inReady),  64'd1);
    applyStimulus(1'b0, I_ZERO, '0, 1'b1, 1'b0);
    tick();
    checkOutput("fl2_after", 64'(outValid), 64'd0);

    // Flush in state ONE while a beat is accepted: that beat is dropped
    applyStimulus(1'b1, I_SW, 64'h400, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, I_LUI, 64'h404, 1'b0, 1'b1);
    tick();
    checkOutput("fl1_valid", 64'(outValid), 64'd0);
    applyStimulus(1'b0, I_ZERO, '0, 1'b1, 1'b0);
    tick();
    checkOutput("fl1_after", 64'(outValid), 64'd0);

    // Reset mid-stream, then check first-beat latency
    applyStimulus(1'b1, I_SW, 64'h500, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, I_BEQ, 64'h504, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    applyStimulus(1'b0, I_ZERO, '0, 1'b0, 1'b0);
    tick();
    checkOutput("mrst_valid", 64'(outValid), 64'd0);
    checkOutput("mrst_ready", 64'(inReady),  64'd1);
    checkOutput("mrst_fmt",   64'(outFmt),   64'd6);
    checkOutput("mrst_imm",   outImm,        64'd0);
    checkOutput("mrst_pc",    outPc,         64'd0);
    rst = 1'b0;
    applyStimulus(1'b1, I_ADDI, 64'h600, 1'b1, 1'b0);
    tick();
    checkOutput("post_valid", 64'(outValid), 64'd1);
    checkOutput("post_pc",    outPc,         64'h600);
    checkOutput("post_fmt",   64'(outFmt),   64'd1);
    applyStimulus(1'b0, I_ZERO, '0, 1'b1, 1'b0);
    tick();
    checkOutput("post_drain", 64'(outValid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Registered RV instruction-decode stage that splits a fetched 32-bit word into its fields. It also builds the sign-extended immediate for every base format, classifies the format, and flags illegal encodings. It sits between fetch and register-read and uses valid/ready handshakes on both sides. An internal two-entry skid buffer gives full throughput with a registered `in_ready`, and a synchronous flush discards in-flight beats on redirect.

## Interface
Parameters:
- `XLEN`, 32, immediate/PC width (32 or 64); immediate sign-extended to this width
- `PC_EN`, 1, 1 = carry `in_pc` through to `out_pc`; 0 = `out_pc` tied to 0

Ports:
- `clk`  in  1  clock; one clock domain
- `rst`  in  1  reset; synchronous, active-high
- `flush`  in  1  synchronous discard of all held and incoming beats
- `in_valid`  in  1  fetch beat valid
- `in_ready`  out  1  stage can accept; registered
- `in_instr`  in  32  raw instruction word
- `in_pc`  in  XLEN  PC of `in_instr`
- `out_valid`  out  1  decoded beat valid
- `out_ready`  in  1  consumer accepts
- `out_pc`  out  XLEN  PC of the decoded beat
- `out_opcode`  out  7  bits [6:0]
- `out_rd`  out  5  bits [11:7]
- `out_func3`  out  3  bits [14:12]
- `out_rs1`  out  5  bits [19:15]
- `out_rs2`  out  5  bits [24:20]
- `out_func7`  out  7  bits [31:25]
- `out_imm`  out  XLEN  sign-extended immediate; 0 for R-format and illegal encodings
- `out_fmt`  out  3  format code: R, I, S, B, U, J, NONE
- `out_illegal`  out  1  unsupported opcode, or bits [1:0] ≠ 2'b11

## Operation
- Decode is combinational on the input word. The result is captured into the main register.
- Formats by opcode:
  - I: LOAD 0000011, OP-IMM 0010011, JALR 1100111, MISC-MEM 0001111, SYSTEM 1110011.
  - S: STORE 0100011.
  - B: BRANCH 1100011.
  - U: LUI 0110111, AUIPC 0010111.
  - J: JAL 1101111.
  - R: OP 0110011.
  - Anything else is NONE with `out_illegal` = 1.
- Immediates use the standard RV bit placement. B and J immediates have bit 0 = 0. The U immediate is {instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN = 64.
- Storage has two entries: main (drives the outputs) and skid. Occupancy states are EMPTY, ONE and TWO.
  - EMPTY → ONE on accept.
  - ONE → TWO on accept without pop.
  - ONE → EMPTY on pop without accept.
  - ONE stays ONE on simultaneous accept and pop.
  - TWO → ONE on pop; the skid entry moves into main.
- In TWO, `in_ready` = 0.
- `in_ready` next = 1 unless the next state is TWO.
- Accept = `in_valid` & `in_ready`. Pop = `out_valid` & `out_ready`.
- Ordering is strict FIFO. The skid entry always holds the younger beat.
- Flush takes priority over everything:
  - Both entries are invalidated next cycle.
  - A beat accepted in the flush cycle is dropped.
  - A pop in the flush cycle still completes.
  - Next state is EMPTY with `in_ready` = 1.

## Timing
- Reset values: `out_valid` = 0, `in_ready` = 1. All data outputs are 0 and `out_fmt` = NONE.
- Reset asserted mid-stream behaves like flush; no beat survives.
- Latency: accept in cycle N gives `out_valid` = 1 in cycle N+1 if main was empty or popped in cycle N.
- Throughput: one beat per cycle with `out_ready` held high.
- While `out_valid` = 1 and `out_ready` = 0, all `out_*` signals stay stable.
- `in_ready` has no combinational path from `out_ready`. `out_valid` has no combinational path from `in_valid`.

## Structure
- Shared package `decode_pkg`:
  - opcode localparams
  - `fmt_e` enum (R, I, S, B, U, J, NONE)
  - `decoded_t` packed struct holding the field set, imm, fmt, illegal and pc
- Sub-module `instr_field_decode`: purely combinational, 32-bit word → `decoded_t`. The stage instantiates it once, on the input side.
- The stage itself owns the occupancy state, the main and skid registers, and the handshake.

## Test plan
- `0xFFF00093` (addi x1,x0,-1), `out_ready` = 1 → next cycle: opcode 0x13, rd 1, rs1 0, imm all-ones, fmt I, illegal 0.
- Stream `0x0020A423` (sw x2,8(x1)) → fmt S, rs1 1, rs2 2, imm 8. Then `0xFE000EE3` (beq x0,x0,-4) → fmt B, imm −4. Then `0x001000EF` (jal x1,2048) → fmt J, imm 0x800. Back-to-back with no bubbles.
- `0x123452B7` (lui x5,0x12345) at XLEN = 64 → imm 0x0000_0000_1234_5000, fmt U. `0x00000000` → illegal 1, fmt NONE, imm 0.
- `out_ready` = 0, offer beats A, B, C → A and B accepted; `in_ready` = 0 the cycle after B; C held. Release `out_ready` → A, B, C emerge in order; outputs stable while stalled.
- In state TWO, assert `flush` with `in_valid` = 1 → next cycle `out_valid` = 0 and `in_ready` = 1. The incoming beat never appears.
- Assert `rst` for one cycle mid-stream → all outputs at reset values next cycle. The first beat after release has 1-cycle latency.
